// File: rtl/cache_line_mem_responder_if.sv
// rtl/cache_line_mem_responder_if.sv - request/response stream bundle between cache and memory responder
interface cache_line_mem_responder_if;
    logic [76:0] memreq_msg;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [46:0] memresp_msg;
    logic        memresp_val;
    logic        memresp_rdy;

    modport master (
        output memreq_msg, memreq_val, memresp_rdy,
        input  memreq_rdy, memresp_msg, memresp_val
    );

    modport slave (
        input  memreq_msg, memreq_val, memresp_rdy,
        output memreq_rdy, memresp_msg, memresp_val
    );
endinterface

// File: rtl/cache_line_mem_responder.sv
// rtl/cache_line_mem_responder.sv - fixed-latency in-order word memory backing the cache refill/evict path
module cache_line_mem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    cache_line_mem_responder_if.slave       mem,
    input  logic                            init_en,
    input  logic [31:0]                     init_addr,
    input  logic [31:0]                     init_data,
    output logic [15:0]                     num_reads,
    output logic [15:0]                     num_writes
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int NS = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int OW = $clog2(QDEPTH + LATENCY + 1);

    logic [2:0]  req_type;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    logic        req_is_wr;
    logic        accept;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] init_idx;
    logic        unused_addr_bits;

    assign req_type   = mem.memreq_msg[76:74];
    assign req_opaque = mem.memreq_msg[73:66];
    assign req_addr   = mem.memreq_msg[65:34];
    assign req_len    = mem.memreq_msg[33:32];
    assign req_data   = mem.memreq_msg[31:0];
    assign req_is_wr  = (req_type == 3'd1);
    assign accept     = mem.memreq_val && mem.memreq_rdy;
    assign req_idx    = req_addr[AW+1:2];
    assign init_idx   = init_addr[AW+1:2];
    assign unused_addr_bits = ^{req_addr[31:AW+2], init_addr[31:AW+2], init_addr[1:0]};

    // Word array: not reset, so preloaded and written data survive a reset.
    logic [31:0] mem_q [NUM_WORDS];
    logic [31:0] rd_word;
    logic [31:0] wr_base;
    logic [31:0] wr_shift;
    logic [31:0] wr_merged;
    logic [3:0]  len_mask;
    logic [7:0]  lane_mask_wide;
    logic [3:0]  lane_mask;
    logic [46:0] acc_msg;

    always_comb begin
        rd_word  = mem_q[req_idx];
        len_mask = (req_len == 2'd0) ? 4'hF :
                   (req_len == 2'd1) ? 4'h1 :
                   (req_len == 2'd2) ? 4'h3 : 4'h7;
        lane_mask_wide = {4'b0000, len_mask} << req_addr[1:0];
        lane_mask      = lane_mask_wide[3:0];
        wr_shift = req_data << {req_addr[1:0], 3'b000};
        // Untouched lanes take the preload value when init hits the same word.
        wr_base  = (init_en && (init_idx == req_idx)) ? init_data : rd_word;
        wr_merged = wr_base;
        for (int j = 0; j < 4; j++) begin
            if (lane_mask[j]) wr_merged[8*j +: 8] = wr_shift[8*j +: 8];
        end
        acc_msg = {req_type, req_opaque, 2'b00, req_len, req_is_wr ? 32'd0 : rd_word};
    end

    always_ff @(posedge clk) begin
        if (init_en) mem_q[init_idx] <= init_data;
        if (accept && req_is_wr) mem_q[req_idx] <= wr_merged;
    end

    logic          push_val;
    logic [46:0]   push_msg;
    logic [OW-1:0] stage_cnt;

    if (LATENCY > 1) begin : g_delay
        logic [NS-1:0] dv_q, dv_d;
        logic [46:0]   dm_q [NS];
        logic [46:0]   dm_d [NS];

        always_comb begin
            dv_d[0] = accept && !reset;
            dm_d[0] = acc_msg;
            for (int i = 1; i < NS; i++) begin
                dv_d[i] = dv_q[i-1] && !reset;
                dm_d[i] = dm_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            dv_q <= dv_d;
            for (int i = 0; i < NS; i++) dm_q[i] <= dm_d[i];
        end

        always_comb begin
            stage_cnt = '0;
            for (int i = 0; i < NS; i++) stage_cnt = stage_cnt + OW'(dv_q[i]);
        end

        assign push_val = dv_q[NS-1];
        assign push_msg = dm_q[NS-1];
    end else begin : g_nodelay
        assign push_val  = accept;
        assign push_msg  = acc_msg;
        assign stage_cnt = '0;
    end

    logic [46:0]   fifo_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          resp_val;
    logic          pop;
    logic [OW-1:0] occupancy;

    assign resp_val = (count_q != '0);
    assign pop      = resp_val && mem.memresp_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_val) wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push_val) - CW'(pop);
        if (reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        if (push_val) fifo_q[wr_ptr_q] <= push_msg;
    end

    // Credit comes only from registered state, so a full FIFO cannot be overrun.
    assign occupancy       = stage_cnt + OW'(count_q);
    assign mem.memreq_rdy  = (occupancy < OW'(QDEPTH));
    assign mem.memresp_val = resp_val;
    assign mem.memresp_msg = resp_val ? fifo_q[rd_ptr_q] : '0;

    logic [15:0] num_reads_q, num_reads_d;
    logic [15:0] num_writes_q, num_writes_d;

    always_comb begin
        num_reads_d  = num_reads_q;
        num_writes_d = num_writes_q;
        if (accept && !req_is_wr && (num_reads_q != 16'hFFFF))  num_reads_d  = num_reads_q + 16'd1;
        if (accept && req_is_wr && (num_writes_q != 16'hFFFF))  num_writes_d = num_writes_q + 16'd1;
        if (reset) begin
            num_reads_d  = '0;
            num_writes_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        num_reads_q  <= num_reads_d;
        num_writes_q <= num_writes_d;
    end

    assign num_reads  = num_reads_q;
    assign num_writes = num_writes_q;
endmodule

// File: tb/tb_cache_line_mem_responder.sv
// tb/tb_cache_line_mem_responder.sv - scoreboard bench for cache_line_mem_responder
module tb_cache_line_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic [15:0] num_reads;
    logic [15:0] num_writes;

    always #5 clk = ~clk;

    cache_line_mem_responder_if mif ();

    cache_line_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mif),
        .init_en    (init_en),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .num_reads  (num_reads),
        .num_writes (num_writes)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_resp_cyc = 0;
    int c0;
    logic [46:0] exp_q [$];
    logic [46:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mif.memresp_val && mif.memresp_rdy) begin
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_resp: got %0h expected none", mif.memresp_msg);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp_msg", {17'd0, mif.memresp_msg}, {17'd0, mon_exp});
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [1:0] len, input logic [31:0] d, input logic [31:0] exp_data);
        mif.memreq_msg = {t, op, a, len, d};
        mif.memreq_val = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (mif.memreq_rdy) begin
                exp_q.push_back({t, op, 2'b00, len, (t == 3'd1) ? 32'd0 : exp_data});
                @(posedge clk);
                #1;
                mif.memreq_val = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd1, 64'd0);
        mif.memreq_val = 1'b0;
    endtask

    task automatic do_init(input logic [31:0] a, input logic [31:0] d);
        init_en   = 1'b1;
        init_addr = a;
        init_data = d;
        @(posedge clk);
        #1;
        init_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        init_en         = 1'b0;
        init_addr       = '0;
        init_data       = '0;
        mif.memreq_val  = 1'b0;
        mif.memreq_msg  = '0;
        mif.memresp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_memreq_rdy", 64'(mif.memreq_rdy), 64'd1);
        chk("rst_memresp_val", 64'(mif.memresp_val), 64'd0);
        chk("rst_memresp_msg", 64'(mif.memresp_msg), 64'd0);
        chk("rst_num_reads", 64'(num_reads), 64'd0);
        chk("rst_num_writes", 64'(num_writes), 64'd0);
        @(posedge clk);
        #1;

        // preload and fixed latency
        do_init(32'h14, 32'hDEADBEEF);
        send(3'd0, 8'h03, 32'h14, 2'd0, 32'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("lat_t1_val", 64'(mif.memresp_val), 64'd0);
        @(negedge clk);
        chk("lat_t2_val", 64'(mif.memresp_val), 64'd1);
        @(posedge clk);
        #1;

        // write then read same word back-to-back
        send(3'd1, 8'h10, 32'h100, 2'd0, 32'h12345678, 32'd0);
        send(3'd0, 8'h11, 32'h100, 2'd0, 32'd0, 32'h12345678);
        wait_drain();
        chk("wr_rd_num_writes", 64'(num_writes), 64'd1);
        chk("wr_rd_num_reads", 64'(num_reads), 64'd2);
        @(posedge clk);
        #1;

        // line evict then refill at full throughput
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            send(3'd1, 8'(8'h20 + i), 32'(32'h200 + 4 * i), 2'd0, 32'(32'hA0A00000 + i), 32'd0);
        for (int i = 0; i < 4; i++)
            send(3'd0, 8'(8'h24 + i), 32'(32'h200 + 4 * i), 2'd0, 32'd0, 32'(32'hA0A00000 + i));
        chk("burst_accept_cycles", 64'(cyc - c0), 64'd8);
        wait_drain();
        chk("burst_last_resp_cyc", 64'(last_resp_cyc), 64'(c0 + 9));
        chk("burst_num_writes", 64'(num_writes), 64'd5);
        chk("burst_num_reads", 64'(num_reads), 64'd6);
        @(posedge clk);
        #1;

        // backpressure: only QDEPTH accepted while responses are stalled
        mif.memresp_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(3'd0, 8'(8'h30 + i), 32'(32'h200 + 4 * i), 2'd0, 32'd0, 32'(32'hA0A00000 + i));
                send(3'd0, 8'h34, 32'h100, 2'd0, 32'd0, 32'h12345678);
                send(3'd0, 8'h35, 32'h14, 2'd0, 32'd0, 32'hDEADBEEF);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("bp_memreq_rdy", 64'(mif.memreq_rdy), 64'd0);
                chk("bp_num_reads", 64'(num_reads), 64'd10);
                chk("bp_memresp_val", 64'(mif.memresp_val), 64'd1);
                chk("bp_head_msg", 64'(mif.memresp_msg), 64'(exp_q[0]));
                @(negedge clk);
                chk("bp_head_stable", 64'(mif.memresp_msg), 64'(exp_q[0]));
                @(posedge clk);
                #1 mif.memresp_rdy = 1'b1;
            end
        join
        wait_drain();
        chk("bp_num_reads_final", 64'(num_reads), 64'd12);
        @(posedge clk);
        #1;

        // partial writes, init collision, odd type, address wrap
        do_init(32'h40, 32'hAABBCCDD);
        send(3'd1, 8'h40, 32'h41, 2'd2, 32'h00001122, 32'd0);
        send(3'd0, 8'h41, 32'h40, 2'd0, 32'd0, 32'hAA1122DD);
        send(3'd1, 8'h42, 32'h43, 2'd3, 32'h00334455, 32'd0);
        send(3'd0, 8'h43, 32'h40, 2'd0, 32'd0, 32'h551122DD);
        init_en   = 1'b1;
        init_addr = 32'h44;
        init_data = 32'h99999999;
        send(3'd1, 8'h44, 32'h44, 2'd1, 32'h00000077, 32'd0);
        init_en = 1'b0;
        send(3'd0, 8'h45, 32'h44, 2'd0, 32'd0, 32'h99999977);
        send(3'd5, 8'h46, 32'h44, 2'd0, 32'd0, 32'h99999977);
        send(3'd0, 8'h47, 32'hFFFFFC14, 2'd1, 32'd0, 32'hDEADBEEF);
        wait_drain();
        @(posedge clk);
        #1;

        // reset with transactions in flight
        mif.memresp_rdy = 1'b0;
        send(3'd0, 8'h50, 32'h14, 2'd0, 32'd0, 32'hDEADBEEF);
        send(3'd0, 8'h51, 32'h100, 2'd0, 32'd0, 32'h12345678);
        send(3'd0, 8'h52, 32'h200, 2'd0, 32'd0, 32'hA0A00000);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        mif.memresp_rdy = 1'b1;
        @(negedge clk);
        chk("rst2_memresp_val", 64'(mif.memresp_val), 64'd0);
        chk("rst2_memreq_rdy", 64'(mif.memreq_rdy), 64'd1);
        chk("rst2_num_reads", 64'(num_reads), 64'd0);
        chk("rst2_num_writes", 64'(num_writes), 64'd0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        send(3'd0, 8'h60, 32'h100, 2'd0, 32'd0, 32'h12345678);
        wait_drain();
        chk("rst2_num_reads_after", 64'(num_reads), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
